// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: drain FSM encoding and the queued entry layout.
package store_buffer_pkg;
  typedef enum logic {SB_IDLE = 1'b0, SB_BUSY = 1'b1} sb_state_e;

  localparam int ADDR_HI_W = 30;
  localparam int STRB_W    = 4;
  localparam int DATA_W    = 32;
  localparam int DATA_LSB  = 0;
  localparam int STRB_LSB  = DATA_LSB + DATA_W;
  localparam int ADDR_LSB  = STRB_LSB + STRB_W;
  localparam int ENTRY_W   = ADDR_HI_W + STRB_W + DATA_W;

  // {addr[31:2], strb, data}
  typedef struct packed {
    logic [ADDR_HI_W-1:0] addr_hi;
    logic [STRB_W-1:0]    strb;
    logic [DATA_W-1:0]    data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_fifo.sv
// Register-array FIFO holding committed stores; exposes per-entry addresses and
// a valid mask so the top can compare loads against every pending word.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  sb_entry_t                     wdata_i,
  output sb_entry_t                     head_o,
  output sb_entry_t                     next_o,
  output logic [PTR_W:0]                count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH*ADDR_HI_W-1:0]    addrs_o,
  output logic [DEPTH-1:0]              vld_o
);
  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q, rd_nxt;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  assign rd_nxt = rd_q + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_q] = 1'b0;
    if (push_i) vld_d[wr_q] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_nxt;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_nxt];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign vld_o   = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_addr
    assign addrs_o[i*ADDR_HI_W +: ADDR_HI_W] = mem_q[i].addr_hi;
  end
endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues committed stores, drains them over a WREN/WACK port and
// flags memory-stage loads that hit a pending store word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EXT_STALL,
  input  logic        W_VALID,
  input  logic        W_STORE_WREN,
  input  logic [31:0] W_STORE_ADDR,
  input  logic [3:0]  W_STORE_STRB,
  input  logic [31:0] W_STORE_DATA,
  output logic        SB_STALL,
  output logic        SB_EMPTY,
  input  logic        LD_CHK_VALID,
  input  logic [31:0] LD_CHK_ADDR,
  output logic        LD_HAZARD,
  output logic        MEM_WREN,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_DATA,
  input  logic        MEM_WACK
);
  logic                       push_req, push, pop, full, empty, hz_q;
  logic [PTR_W:0]             count;
  logic [DEPTH*ADDR_HI_W-1:0] addrs;
  logic [DEPTH-1:0]           vld;
  sb_entry_t                  wr_ent, head, nxt, out_q, out_d;
  sb_state_e                  state_q, state_d;
  logic                       wren_q, wren_d;
  logic                       unused_lsb;

  assign unused_lsb = ^{W_STORE_ADDR[1:0], LD_CHK_ADDR[1:0]};

  assign push_req = W_VALID & W_STORE_WREN;
  assign push     = push_req & ~full & ~EXT_STALL;
  assign SB_STALL = push_req & full;
  assign SB_EMPTY = empty & ~push_req;
  assign wr_ent   = '{addr_hi: W_STORE_ADDR[31:2], strb: W_STORE_STRB, data: W_STORE_DATA};

  store_buffer_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .CLK(CLK), .RST(RST), .push_i(push), .pop_i(pop), .wdata_i(wr_ent),
    .head_o(head), .next_o(nxt), .count_o(count), .full_o(full), .empty_o(empty),
    .addrs_o(addrs), .vld_o(vld)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= SB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: if (!empty) state_d = SB_BUSY;
      SB_BUSY: if (MEM_WACK && count <= (PTR_W+1)'(1)) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  // The in-flight head stays in the FIFO until acked, so the follow-on entry is next_o.
  always_comb begin
    pop    = 1'b0;
    wren_d = wren_q;
    out_d  = out_q;
    case (state_q)
      SB_IDLE: if (!empty) begin
        wren_d = 1'b1;
        out_d  = head;
      end
      SB_BUSY: if (MEM_WACK) begin
        pop = 1'b1;
        if (count > (PTR_W+1)'(1)) begin
          wren_d = 1'b1;
          out_d  = nxt;
        end else begin
          wren_d = 1'b0;
        end
      end
      default: wren_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wren_q <= 1'b0;
      out_q  <= '0;
    end else begin
      wren_q <= wren_d;
      out_q  <= out_d;
    end
  end

  assign MEM_WREN = wren_q;
  assign MEM_ADDR = {out_q.addr_hi, 2'b00};
  assign MEM_STRB = out_q.strb;
  assign MEM_DATA = out_q.data;

  always_comb begin
    hz_q = push_req && (W_STORE_ADDR[31:2] == LD_CHK_ADDR[31:2]);
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && addrs[i*ADDR_HI_W +: ADDR_HI_W] == LD_CHK_ADDR[31:2]) hz_q = 1'b1;
  end

  assign LD_HAZARD = LD_CHK_VALID & hz_q;
endmodule
